// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V BRAM arbiter: access-size selector, arbiter
// state encoding, grant indices and a helper that maps an access size to the
// index of its last byte.
package riscv_pkg;

  // Access size requested by a port.
  typedef enum logic [1:0] {
    MASK_B = 2'b00,
    MASK_H = 2'b01,
    MASK_W = 2'b10
  } MASK_SEL;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DRAIN  = 2'b10,
    RESP   = 2'b11
  } arb_state_e;

  // Grant index: which requester owns the current transfer.
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;

  // Index of the final byte of an access (n-1 for n = 1/2/4 bytes).
  function automatic logic [1:0] mask_last(input MASK_SEL m);
    logic [1:0] last;
    case (m)
      MASK_B:  last = 2'd0;
      MASK_H:  last = 2'd1;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/riscv_bram_arbiter_if.sv
// Bus bundle between the two requesters (core data port and program loader),
// the arbiter and the shared byte-wide BRAM. The arbiter uses the slave view;
// the requesters and the memory together form the master view.
interface riscv_bram_arbiter_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) ();
  import riscv_pkg::*;

  // Core data port
  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_LENGTH-1:0] cpu_addr;
  logic [WORD_LENGTH-1:0] cpu_wdata;
  MASK_SEL                cpu_mask_sel;
  logic                   cpu_ack;
  logic [WORD_LENGTH-1:0] cpu_rdata;

  // Program loader port
  logic                   ldr_req;
  logic                   ldr_we;
  logic [ADDR_LENGTH-1:0] ldr_addr;
  logic [WORD_LENGTH-1:0] ldr_wdata;
  MASK_SEL                ldr_mask_sel;
  logic                   ldr_ack;
  logic [WORD_LENGTH-1:0] ldr_rdata;

  // Shared byte-wide BRAM (read data one cycle after the address)
  logic                   bram_write_en;
  logic [ADDR_LENGTH-1:0] bram_waddr;
  logic [ADDR_LENGTH-1:0] bram_raddr;
  logic [7:0]             bram_wdata;
  logic [7:0]             bram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask_sel,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_mask_sel,
    output ldr_ack, ldr_rdata,
    output bram_write_en, bram_waddr, bram_raddr, bram_wdata,
    input  bram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask_sel,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_mask_sel,
    input  ldr_ack, ldr_rdata,
    input  bram_write_en, bram_waddr, bram_raddr, bram_wdata,
    output bram_dout
  );

endinterface

// File: rtl/riscv_arb_pick.sv
// Grant selection for the two requesters. A lone request always wins; on a
// collision the pointer names the winner.
module riscv_arb_pick
  import riscv_pkg::*;
(
  input  logic req_cpu_i,
  input  logic req_ldr_i,
  input  logic ptr_i,
  output logic gnt_o
);

  // Choose the winner among the active requests.
  always_comb begin
    gnt_o = GNT_CPU;
    if (req_cpu_i && req_ldr_i) begin
      gnt_o = ptr_i;
    end else if (req_ldr_i) begin
      gnt_o = GNT_LDR;
    end
  end

endmodule

// File: rtl/riscv_bram_arbiter.sv
// Arbiter that serialises word/halfword/byte accesses from the core data port
// and the program loader onto one byte-wide BRAM, one byte per cycle.
// Sequence: IDLE -> ACCESS (n cycles) -> DRAIN -> RESP (ack pulse) -> IDLE.
// Optional feature: define RISCV_BRAM_ARB_RR_EN to resolve collisions
// round-robin instead of with fixed core priority.
module riscv_bram_arbiter
  import riscv_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  riscv_bram_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [1:0]             k_q, k_d;          // byte counter within the access
  logic [1:0]             last_q, last_d;    // index of the final byte
  logic                   gnt_q, gnt_d;      // owner of the current transfer
  logic                   we_q, we_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] rdata_q, rdata_d;

  logic       any_req;
  logic       pick_gnt;
  logic       ptr;
  logic       cap_en;
  logic [1:0] cap_idx;
  logic       write_en;
  logic       cpu_ack;
  logic       ldr_ack;

  assign any_req = bus.cpu_req | bus.ldr_req;

  riscv_arb_pick u_pick (
    .req_cpu_i (bus.cpu_req),
    .req_ldr_i (bus.ldr_req),
    .ptr_i     (ptr),
    .gnt_o     (pick_gnt)
  );

`ifdef RISCV_BRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // After a collision the loser becomes the preferred port for the next one.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && bus.cpu_req && bus.ldr_req) begin
      ptr_d = ~pick_gnt;
    end
  end

  // Collision pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= GNT_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = GNT_CPU;
`endif

  // Next-state, operand latching, read-byte capture and handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cap_en   = 1'b0;
    cap_idx  = k_q - 2'd1;
    write_en = 1'b0;
    cpu_ack  = 1'b0;
    ldr_ack  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = pick_gnt;
          if (pick_gnt == GNT_LDR) begin
            we_d    = bus.ldr_we;
            addr_d  = bus.ldr_addr;
            wdata_d = bus.ldr_wdata;
            last_d  = mask_last(bus.ldr_mask_sel);
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            last_d  = mask_last(bus.cpu_mask_sel);
          end
          k_d     = 2'd0;
          rdata_d = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        write_en = we_q;
        // The byte addressed in the previous cycle is on bram_dout now.
        cap_en   = (k_q != 2'd0);
        k_d      = k_q + 2'd1;
        if (k_q == last_q) begin
          k_d     = 2'd0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        cap_en  = 1'b1;
        cap_idx = last_q;
        state_d = RESP;
      end

      RESP: begin
        cpu_ack = (gnt_q == GNT_CPU);
        ldr_ack = (gnt_q == GNT_LDR);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // rdata was cleared at accept, so OR-ing leaves unaccessed bytes at zero.
    if (cap_en) begin
      rdata_d = rdata_q | (WORD_LENGTH'(bus.bram_dout) << {cap_idx, 3'b000});
    end
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      last_q  <= 2'd0;
      gnt_q   <= GNT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that existed before this edge, independent of statement order.
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // BRAM side: byte k of the latched word at base+k, wrapping naturally.
  assign bus.bram_write_en = write_en;
  assign bus.bram_waddr    = addr_q + ADDR_LENGTH'(k_q);
  assign bus.bram_raddr    = addr_q + ADDR_LENGTH'(k_q);
  assign bus.bram_wdata    = 8'(wdata_q >> {k_q, 3'b000});

  // Requester side: rdata is shared and only meaningful with the owner's ack.
  assign bus.cpu_ack   = cpu_ack;
  assign bus.ldr_ack   = ldr_ack;
  assign bus.cpu_rdata = rdata_q;
  assign bus.ldr_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_bram_arbiter.sv
// Self-checking bench for riscv_bram_arbiter: directed accesses, collisions,
// reset mid-transfer and a randomized two-port phase. Expected responses come
// from a byte-addressed reference memory and are queued per port at issue;
// a monitor pops and compares on every ack.
module tb_riscv_bram_arbiter;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  riscv_bram_arbiter_if #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) bus ();

  riscv_bram_arbiter #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_cpu[$];
  exp_t exp_ldr[$];
  bit   ack_order[$];
  bit [7:0] ref_mem [bit [31:0]];

  // BRAM model: registered read, one-cycle latency; 64 KiB window of the space.
  // NOTE: the model storage is 2-state and never reset; it simply starts at 0.
  bit [7:0] mem [0:65535];
  always @(posedge clk) begin
    bus.bram_dout <= mem[bus.bram_raddr[15:0]];
    if (bus.bram_write_en) mem[bus.bram_waddr[15:0]] <= bus.bram_wdata;
  end

  function automatic int size_of(input MASK_SEL m);
    case (m)
      MASK_B:  return 1;
      MASK_H:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Issue one access on a port (0 = cpu, 1 = ldr); starts and ends just after
  // a rising edge. lat counts cycles from the accepting edge to the ack cycle.
  task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input MASK_SEL m,
                        output int lat, output logic [31:0] rd);
    exp_t e;
    int   n = size_of(m);
    e.is_load = !we;
    e.rdata   = '0;
    for (int i = 0; i < n; i++) begin
      bit [31:0] a;
      a = addr + 32'(i);
      if (we) ref_mem[a] = wdata[8*i +: 8];
      else    e.rdata[8*i +: 8] = ref_rd(a);
    end
    if (port) exp_ldr.push_back(e);
    else      exp_cpu.push_back(e);

    if (port) begin
      bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
      bus.ldr_mask_sel = m; bus.ldr_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      bus.cpu_mask_sel = m; bus.cpu_req = 1'b1;
    end

    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (port ? bus.ldr_ack : bus.cpu_ack) begin
        lat = c - 1;
        rd  = port ? bus.ldr_rdata : bus.cpu_rdata;
        break;
      end
    end
    check(port ? "ldr_ack_in_budget" : "cpu_ack_in_budget", 64'(lat >= 0), 64'd1);

    @(posedge clk);
    #1;
    if (port) bus.ldr_req = 1'b0;
    else      bus.cpu_req = 1'b0;
  endtask

  // Scoreboard monitor: every ack must match the oldest expectation of its port.
  logic cpu_ack_p = 1'b0;
  logic ldr_ack_p = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      cpu_ack_p <= 1'b0;
      ldr_ack_p <= 1'b0;
    end else begin
      cpu_ack_p <= bus.cpu_ack;
      ldr_ack_p <= bus.ldr_ack;
      if (bus.cpu_ack || bus.ldr_ack)
        check("ack_exclusive", 64'(bus.cpu_ack & bus.ldr_ack), 64'd0);
      if (bus.cpu_ack) begin
        check("cpu_ack_single_cycle", 64'(cpu_ack_p), 64'd0);
        check("cpu_ack_expected", 64'(exp_cpu.size() != 0), 64'd1);
        if (exp_cpu.size() != 0) begin
          if (exp_cpu[0].is_load) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(exp_cpu[0].rdata));
          exp_cpu.delete(0);
        end
        ack_order.push_back(1'b0);
      end
      if (bus.ldr_ack) begin
        check("ldr_ack_single_cycle", 64'(ldr_ack_p), 64'd0);
        check("ldr_ack_expected", 64'(exp_ldr.size() != 0), 64'd1);
        if (exp_ldr.size() != 0) begin
          if (exp_ldr[0].is_load) check("ldr_rdata", 64'(bus.ldr_rdata), 64'(exp_ldr[0].rdata));
          exp_ldr.delete(0);
        end
        ack_order.push_back(1'b1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    bit          second_first;

    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_mask_sel = MASK_B;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.ldr_mask_sel = MASK_B;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack",   64'(bus.cpu_ack), 64'd0);
    check("rst_ldr_ack",   64'(bus.ldr_ack), 64'd0);
    check("rst_write_en",  64'(bus.bram_write_en), 64'd0);
    check("rst_waddr",     64'(bus.bram_waddr), 64'd0);
    check("rst_raddr",     64'(bus.bram_raddr), 64'd0);
    check("rst_wdata",     64'(bus.bram_wdata), 64'd0);
    check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    check("rst_ldr_rdata", 64'(bus.ldr_rdata), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Word store
    do_req(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, MASK_W, lat, rd);
    check("w_store_latency", 64'(lat), 64'd6);
    check("w_store_b10", 64'(mem[16'h10]), 64'hD4);
    check("w_store_b11", 64'(mem[16'h11]), 64'hC3);
    check("w_store_b12", 64'(mem[16'h12]), 64'hB2);
    check("w_store_b13", 64'(mem[16'h13]), 64'hA1);

    // Halfword load, zero-extended
    do_req(1'b0, 1'b0, 32'h12, 32'h0, MASK_H, lat, rd);
    check("h_load_latency", 64'(lat), 64'd4);
    check("h_load_data", 64'(rd), 64'h0000A1B2);

    // Loader byte store touches one byte only
    do_req(1'b1, 1'b1, 32'h11, 32'hFFFFFF5E, MASK_B, lat, rd);
    check("b_store_latency", 64'(lat), 64'd3);
    check("b_store_b10", 64'(mem[16'h10]), 64'hD4);
    check("b_store_b11", 64'(mem[16'h11]), 64'h5E);
    check("b_store_b12", 64'(mem[16'h12]), 64'hB2);

    // Address wrap at the top of the space
    do_req(1'b0, 1'b1, 32'hFFFFFFFE, 32'h44332211, MASK_W, lat, rd);
    check("wrap_b_fffe", 64'(mem[16'hFFFE]), 64'h11);
    check("wrap_b_ffff", 64'(mem[16'hFFFF]), 64'h22);
    check("wrap_b_0000", 64'(mem[16'h0000]), 64'h33);
    check("wrap_b_0001", 64'(mem[16'h0001]), 64'h44);
    do_req(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, MASK_W, lat, rd);
    check("wrap_load_latency", 64'(lat), 64'd6);
    check("wrap_load_data", 64'(rd), 64'h44332211);

    // Two collisions in succession
    ack_order.delete();
    fork
      begin int l1; logic [31:0] r1; do_req(1'b0, 1'b0, 32'h10, 32'h0, MASK_W, l1, r1); end
      begin int l2; logic [31:0] r2; do_req(1'b1, 1'b0, 32'h12, 32'h0, MASK_H, l2, r2); end
    join
    check("coll1_count", 64'(ack_order.size()), 64'd2);
    check("coll1_first", 64'(ack_order[0]), 64'd0);
    check("coll1_second", 64'(ack_order[1]), 64'd1);
    ack_order.delete();
    fork
      begin int l3; logic [31:0] r3; do_req(1'b0, 1'b0, 32'h11, 32'h0, MASK_B, l3, r3); end
      begin int l4; logic [31:0] r4; do_req(1'b1, 1'b0, 32'h10, 32'h0, MASK_W, l4, r4); end
    join
`ifdef RISCV_BRAM_ARB_RR_EN
    second_first = 1'b1;
`else
    second_first = 1'b0;
`endif
    check("coll2_count", 64'(ack_order.size()), 64'd2);
    check("coll2_first", 64'(ack_order[0]), 64'(second_first));
    check("coll2_second", 64'(ack_order[1]), 64'(!second_first));

    // Reset during byte 2 of a word store to 0x20
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h8899AABB;
    bus.cpu_mask_sel = MASK_W; bus.cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("abort_pre_we", 64'(bus.bram_write_en), 64'd1);
    check("abort_pre_addr", 64'(bus.bram_waddr), 64'h22);
    check("abort_pre_wdata", 64'(bus.bram_wdata), 64'h99);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check("abort_we", 64'(bus.bram_write_en), 64'd0);
    check("abort_ack", 64'(bus.cpu_ack), 64'd0);
    check("abort_waddr", 64'(bus.bram_waddr), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_b20", 64'(mem[16'h20]), 64'hBB);
    check("abort_b21", 64'(mem[16'h21]), 64'hAA);
    check("abort_b22", 64'(mem[16'h22]), 64'h00);
    check("abort_b23", 64'(mem[16'h23]), 64'h00);
    ref_mem[32'h20] = 8'hBB;
    ref_mem[32'h21] = 8'hAA;
    do_req(1'b0, 1'b0, 32'h20, 32'h0, MASK_W, lat, rd);
    check("post_abort_latency", 64'(lat), 64'd6);
    check("post_abort_data", 64'(rd), 64'h0000AABB);

    // Randomized traffic on both ports in disjoint regions
    fork
      begin
        bit we_c; logic [31:0] a_c, d_c; MASK_SEL m_c; int g_c, l_c; logic [31:0] r_c;
        for (int t = 0; t < 40; t++) begin
          we_c = 1'($urandom_range(0, 1));
          a_c  = 32'h1000 + 32'($urandom_range(0, 250));
          d_c  = $urandom;
          m_c  = MASK_SEL'(2'($urandom_range(0, 2)));
          do_req(1'b0, we_c, a_c, d_c, m_c, l_c, r_c);
          g_c = int'($urandom_range(0, 3));
          repeat (g_c) @(posedge clk);
          if (g_c > 0) #1;
        end
      end
      begin
        bit we_l; logic [31:0] a_l, d_l; MASK_SEL m_l; int g_l, l_l; logic [31:0] r_l;
        for (int t = 0; t < 40; t++) begin
          we_l = 1'($urandom_range(0, 1));
          a_l  = 32'h2000 + 32'($urandom_range(0, 250));
          d_l  = $urandom;
          m_l  = MASK_SEL'(2'($urandom_range(0, 2)));
          do_req(1'b1, we_l, a_l, d_l, m_l, l_l, r_l);
          g_l = int'($urandom_range(0, 3));
          repeat (g_l) @(posedge clk);
          if (g_l > 0) #1;
        end
      end
    join

    repeat (4) @(posedge clk);
    #1;
    check("cpu_queue_drained", 64'(exp_cpu.size()), 64'd0);
    check("ldr_queue_drained", 64'(exp_ldr.size()), 64'd0);
    foreach (ref_mem[a]) begin
      check($sformatf("mem_%08h", a), 64'(mem[a[15:0]]), 64'(ref_mem[a]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
